// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe
//   Registered binary-to-one-hot decoder with a valid/ready handshake on both
//   sides. A per-code enable mask turns disabled codes into "misses" that still
//   produce a defined output word. A saturating counter tracks accepted misses.
//
//   Optional feature: define ONEHOT_DECODER_SWEEP_EN to compile in a self-test
//   sweep that feeds codes 0..OUT_W-1 through the same pipeline. Without it the
//   sweep_start input is ignored and sweep_busy is tied low.
//
// Parameters
//   ADDR_W        input code width; OUT_W = 1 << ADDR_W
//   HOLD_ON_MISS  0: miss outputs all-zero; 1: miss repeats last non-miss out_y
//   CNT_W         miss_count width
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake, in_addr is the code to decode
//   out_valid/out_ready   output handshake for out_y / out_miss
//   out_y                 one-hot result, or miss value
//   out_miss              delivered code was masked
//   mask_we, mask_wdata   load enable mask (bit k enables code k)
//   miss_count            saturating count of accepted masked codes
//   sweep_start           start self-test sweep
//   sweep_busy            sweep in progress
module onehot_decoder_pipe #(
  parameter int ADDR_W       = 3,
  parameter int HOLD_ON_MISS = 0,
  parameter int CNT_W        = 16,
  localparam int OUT_W       = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_y,
  output logic              out_miss,
  input  logic              mask_we,
  input  logic [OUT_W-1:0]  mask_wdata,
  output logic [CNT_W-1:0]  miss_count,
  input  logic              sweep_start,
  output logic              sweep_busy
);

  logic [OUT_W-1:0]  mask_reg;
  logic [OUT_W-1:0]  out_y_reg;
  logic [OUT_W-1:0]  last_hit_reg;
  logic              out_valid_reg;
  logic              out_miss_reg;
  logic [CNT_W-1:0]  miss_count_reg;

  // Selected source: external port, or the sweep generator when it is busy.
  logic              src_valid;
  logic [ADDR_W-1:0] src_addr;
  logic              sweep_busy_w;

  // Output stage can take a new result this cycle.
  logic out_free;
  logic accept;
  assign out_free = !out_valid_reg || out_ready;
  assign accept   = src_valid && out_free;
  assign in_ready = out_free && !sweep_busy_w;

`ifdef ONEHOT_DECODER_SWEEP_EN
  logic              sweep_busy_reg;
  logic [ADDR_W-1:0] sweep_code_reg;

  // The sweep code advances only when the pipeline actually takes it, so a
  // stalled downstream stretches the sweep rather than dropping codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_busy_reg <= 1'b0;
      sweep_code_reg <= '0;
    end else if (sweep_busy_reg) begin
      if (out_free) begin
        sweep_code_reg <= sweep_code_reg + 1'b1;
        if (sweep_code_reg == ADDR_W'(OUT_W - 1)) begin
          sweep_busy_reg <= 1'b0;
        end
      end
    end else if (sweep_start) begin
      sweep_busy_reg <= 1'b1;
      sweep_code_reg <= '0;
    end
  end

  assign sweep_busy_w = sweep_busy_reg;
  assign src_valid    = sweep_busy_reg ? 1'b1 : in_valid;
  assign src_addr     = sweep_busy_reg ? sweep_code_reg : in_addr;
`else
  logic sweep_start_unused;
  assign sweep_start_unused = sweep_start;
  assign sweep_busy_w       = 1'b0;
  assign src_valid          = in_valid;
  assign src_addr           = in_addr;
`endif

  // One comparator per output bit keeps every code decoded, whatever ADDR_W is.
  logic [OUT_W-1:0] onehot;
  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_dec
      assign onehot[gi] = (src_addr == ADDR_W'(gi));
    end
  endgenerate

  logic             hit;
  logic [OUT_W-1:0] miss_y;
  assign hit    = mask_reg[src_addr];
  assign miss_y = (HOLD_ON_MISS != 0) ? last_hit_reg : '0;

  // Mask write and acceptance in the same cycle: decode reads mask_reg before
  // the edge, so the old mask applies to that code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg <= '1;
    end else if (mask_we) begin
      mask_reg <= mask_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg  <= 1'b0;
      out_y_reg      <= '0;
      out_miss_reg   <= 1'b0;
      last_hit_reg   <= '0;
      miss_count_reg <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_miss_reg  <= !hit;
      out_y_reg     <= hit ? onehot : miss_y;
      if (hit) begin
        last_hit_reg <= onehot;
      end else if (miss_count_reg != {CNT_W{1'b1}}) begin
        miss_count_reg <= miss_count_reg + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_y      = out_y_reg;
  assign out_miss   = out_miss_reg;
  assign miss_count = miss_count_reg;
  assign sweep_busy = sweep_busy_w;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// tb_onehot_decoder_pipe
//   Drives two decoders from the same stimulus: one with default parameters
//   (zero on miss, 16-bit counter) and one with HOLD_ON_MISS=1 and a 2-bit
//   counter so saturation is reached quickly. Expected results are pushed into
//   per-instance queues at issue time and popped by a monitor on delivery.
module tb_onehot_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_addr = '0;
  logic       out_ready = 1'b0;
  logic       mask_we = 1'b0;
  logic [7:0] mask_wdata = '0;
  logic       sweep_start = 1'b0;

  logic        in_ready_a, out_valid_a, out_miss_a, sweep_busy_a;
  logic [7:0]  out_y_a;
  logic [15:0] miss_count_a;
  logic        in_ready_b, out_valid_b, out_miss_b, sweep_busy_b;
  logic [7:0]  out_y_b;
  logic [1:0]  miss_count_b;

  always #5 clk = ~clk;

  onehot_decoder_pipe #(.ADDR_W(3), .HOLD_ON_MISS(0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_addr(in_addr), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_y(out_y_a), .out_miss(out_miss_a), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .miss_count(miss_count_a),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy_a)
  );

  onehot_decoder_pipe #(.ADDR_W(3), .HOLD_ON_MISS(1), .CNT_W(2)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_addr(in_addr), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_y(out_y_b), .out_miss(out_miss_b), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .miss_count(miss_count_b),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy_b)
  );

  typedef struct {
    logic [7:0] y;
    logic       miss;
    int         cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model state
  logic [7:0] mask_m;
  logic [7:0] last_m;
  int         cnt_a_m, cnt_b_m;
  bit         ov_m;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected response for one accepted code, from the decode rules.
  task automatic push_exp(input logic [2:0] a);
    exp_t ea, eb;
    logic [7:0] oh;
    bit hit;
    oh  = 8'(2 ** a);
    hit = mask_m[a];
    if (!hit && cnt_a_m < 65535) cnt_a_m++;
    if (!hit && cnt_b_m < 3) cnt_b_m++;
    ea.y = hit ? oh : 8'h00;
    eb.y = hit ? oh : last_m;
    if (hit) last_m = oh;
    ea.miss = !hit; eb.miss = !hit;
    ea.cnt = cnt_a_m; eb.cnt = cnt_b_m;
    q_a.push_back(ea);
    q_b.push_back(eb);
    $display("issue code=%0d mask=%02h -> y_a=%02h y_h=%02h miss=%0d", a, mask_m, ea.y, eb.y, !hit);
  endtask

  // Monitor: any output taken by downstream must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      if (q_a.size() == 0) begin
        chk("unexpected_out_a", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("out_y_a", out_y_a, e.y);
        chk("out_miss_a", out_miss_a, e.miss);
        chk("miss_count_a", miss_count_a, e.cnt);
      end
    end
    if (rst_n && out_valid_b && out_ready) begin
      if (q_b.size() == 0) begin
        chk("unexpected_out_h", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("out_y_h", out_y_b, e.y);
        chk("out_miss_h", out_miss_b, e.miss);
        chk("miss_count_h", miss_count_b, e.cnt);
      end
    end
  end

  // One clock cycle of stimulus, entered and left 2 time units after posedge.
  task automatic cycle(input logic v, input logic [2:0] a, input logic ordy,
                       input logic mwe, input logic [7:0] md, output bit acc);
    bit ready_m;
    in_valid = v; in_addr = a; out_ready = ordy; mask_we = mwe; mask_wdata = md;
    #1;
    ready_m = !ov_m || ordy;
    chk("in_ready_a", in_ready_a, ready_m);
    chk("in_ready_h", in_ready_b, ready_m);
    acc = v && ready_m;
    if (acc) push_exp(a);
    if (acc) ov_m = 1'b1;
    else if (ordy) ov_m = 1'b0;
    if (mwe) mask_m = md;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; mask_we = 1'b0; sweep_start = 1'b0;
    #1;
    chk("rst_out_valid_a", out_valid_a, 0);
    chk("rst_out_valid_h", out_valid_b, 0);
    chk("rst_out_y_a", out_y_a, 0);
    chk("rst_out_y_h", out_y_b, 0);
    chk("rst_out_miss_a", out_miss_a, 0);
    chk("rst_miss_count_a", miss_count_a, 0);
    chk("rst_miss_count_h", miss_count_b, 0);
    chk("rst_sweep_busy", sweep_busy_a, 0);
    q_a.delete(); q_b.delete();
    mask_m = 8'hFF; last_m = 8'h00; cnt_a_m = 0; cnt_b_m = 0; ov_m = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    $display("reset done t=%0t", $time);
  endtask

  initial begin
    bit acc;
    @(posedge clk);
    #2;
    do_reset();

    // 1: back-to-back stream, one code per cycle
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), 1'b1, 1'b0, 8'h00, acc);

    // 2: masked code 6, then hold behaviour after code 5
    cycle(1'b0, 3'd0, 1'b1, 1'b1, 8'hBF, acc);
    cycle(1'b1, 3'd5, 1'b1, 1'b0, 8'h00, acc);
    cycle(1'b1, 3'd6, 1'b1, 1'b0, 8'h00, acc);

    // 3: downstream stall holding code 3
    cycle(1'b1, 3'd3, 1'b1, 1'b0, 8'h00, acc);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 3'd4, 1'b0, 1'b0, 8'h00, acc);
      chk("stall_out_y", out_y_a, 8'h08);
      chk("stall_out_valid", out_valid_a, 1);
    end
    cycle(1'b1, 3'd4, 1'b1, 1'b0, 8'h00, acc);

    // 4: mask write coinciding with acceptance uses the old mask
    cycle(1'b1, 3'd2, 1'b1, 1'b1, 8'h00, acc);
    cycle(1'b1, 3'd2, 1'b1, 1'b0, 8'h00, acc);

    // 5: saturation of the 2-bit counter
    cycle(1'b0, 3'd0, 1'b1, 1'b0, 8'h00, acc);
    do_reset();
    cycle(1'b0, 3'd0, 1'b1, 1'b1, 8'h00, acc);
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'(i), 1'b1, 1'b0, 8'h00, acc);
    cycle(1'b0, 3'd0, 1'b1, 1'b1, 8'hFF, acc);
    cycle(1'b0, 3'd0, 1'b1, 1'b0, 8'h00, acc);

    // 6: sweep
`ifdef ONEHOT_DECODER_SWEEP_EN
    in_valid = 1'b0; out_ready = 1'b1; sweep_start = 1'b1;
    @(posedge clk); #2;
    sweep_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("sweep_busy", sweep_busy_a, 1);
      chk("sweep_in_ready", in_ready_a, 0);
      push_exp(3'(k));
      ov_m = 1'b1;
      @(posedge clk); #2;
    end
    chk("sweep_done", sweep_busy_a, 0);
    cycle(1'b0, 3'd0, 1'b1, 1'b0, 8'h00, acc);
    in_valid = 1'b0; sweep_start = 1'b1;
    @(posedge clk); #2;
    sweep_start = 1'b0;
    @(posedge clk); #2;
    chk("sweep_mid_busy", sweep_busy_a, 1);
    ov_m = 1'b1;
    do_reset();
    chk("sweep_after_rst", sweep_busy_a, 0);
`else
    in_valid = 1'b0; out_ready = 1'b1; sweep_start = 1'b1;
    @(posedge clk); #2;
    sweep_start = 1'b0;
    #1;
    chk("sweep_ignored_busy", sweep_busy_a, 0);
    chk("sweep_ignored_ready", in_ready_a, 1);
    chk("sweep_ignored_valid", out_valid_a, 0);
    @(posedge clk); #2;
    ov_m = 1'b0;
`endif

    // Randomised traffic with occasional mask rewrites
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
            8'($urandom), acc);
    end

    // Reset while an output is pending
    cycle(1'b1, 3'd5, 1'b0, 1'b0, 8'h00, acc);
    cycle(1'b1, 3'd1, 1'b0, 1'b0, 8'h00, acc);
    chk("pending_before_rst", out_valid_a, 1);
    do_reset();

    // Drain and confirm nothing expected was left undelivered
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 1'b1, 1'b0, 8'h00, acc);
    cycle(1'b1, 3'd7, 1'b1, 1'b0, 8'h00, acc);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 1'b1, 1'b0, 8'h00, acc);
    chk("queue_empty_a", q_a.size(), 0);
    chk("queue_empty_h", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
